// File: rtl/conv_sched_pkg.sv
// Shared definitions for the conv frame scheduler: opaque tag layout,
// FSM encoding and the tag builder.
package conv_sched_pkg;

  localparam int TAG_W         = 8;
  localparam int ID_W          = 3;
  localparam int SEQ_W         = 4;
  localparam int OPQ_VALID_BIT = 7;
  localparam int OPQ_ID_LSB    = 4;
  localparam int OPQ_SEQ_LSB   = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } sched_state_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic [ID_W-1:0] id,
                                                input logic [SEQ_W-1:0] seq);
    return {1'b1, id, seq};
  endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Show-ahead synchronous FIFO holding engine results until the consumer pops.
module conv_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a same-cycle push needs when full.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/conv_frame_scheduler.sv
// Round-robin frame issue to a fixed-latency conv engine with credit-based
// result buffering and drain-before-reload of the filter set.
module conv_frame_scheduler
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IMG_BITS  = 1024,
  parameter int FIL_BITS  = 576,
  parameter int RES_BITS  = 1152,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*IMG_BITS-1:0]  req_img,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [FIL_BITS-1:0]          cfg_fil,
  output logic [IMG_BITS-1:0]          eng_img,
  output logic [FIL_BITS-1:0]          eng_fil,
  output logic [7:0]                   eng_opaque_in,
  input  logic [7:0]                   eng_opaque_out,
  input  logic [RES_BITS-1:0]          eng_result,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2:0]                   res_id,
  output logic [RES_BITS-1:0]          res_data,
  output logic                         busy,
  output logic                         tag_err
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  sched_state_t        state_reg;
  logic [ID_W-1:0]     ptr_reg;
  logic [SEQ_W-1:0]    seq_reg;
  logic [SEQ_W-1:0]    exp_seq_reg;
  logic [CNT_W-1:0]    inflight_reg;
  logic [CNT_W-1:0]    inflight_next;
  logic [FIL_BITS-1:0] eng_fil_reg;
  logic                tag_err_reg;

  logic [IMG_BITS-1:0] img_slice [NUM_REQ];
  logic [IMG_BITS-1:0] img_mux;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                found;
  int                  off;
  int                  best_off;
  logic [CNT_W:0]      credit_sum;
  logic                can_issue;
  logic                issue;
  logic                ret_valid;
  logic [ID_W-1:0]     ret_id;
  logic [SEQ_W-1:0]    ret_seq;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_pop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign img_slice[gi] = req_img[gi*IMG_BITS +: IMG_BITS];
    end
  endgenerate

  // Lowest rotated distance from the pointer wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    off       = 0;
    best_off  = NUM_REQ;
    img_mux   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      off = r - int'(ptr_reg);
      if (off < 0) off = off + NUM_REQ;
      if (req_valid[r] && (off < best_off)) begin
        best_off  = off;
        found     = 1'b1;
        grant     = '0;
        grant[r]  = 1'b1;
        grant_idx = ID_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) img_mux = img_slice[r];
    end
  end

  assign credit_sum = {1'b0, inflight_reg} + {1'b0, fifo_count};
  assign can_issue  = reset && (state_reg == ST_RUN) && !cfg_valid &&
                      (credit_sum < (CNT_W+1)'(OUT_DEPTH));
  assign issue      = can_issue && found;

  assign req_ready     = issue ? grant : '0;
  assign eng_img       = issue ? img_mux : '0;
  assign eng_opaque_in = issue ? make_tag(grant_idx, seq_reg) : '0;

  // With nothing in flight any returning tag is stale and is dropped.
  assign ret_valid = eng_opaque_out[OPQ_VALID_BIT] && (inflight_reg != '0);
  assign ret_id    = eng_opaque_out[OPQ_ID_LSB +: ID_W];
  assign ret_seq   = eng_opaque_out[OPQ_SEQ_LSB +: SEQ_W];

  always_comb begin
    inflight_next = inflight_reg;
    if (issue && !ret_valid)      inflight_next = inflight_reg + 1'b1;
    else if (!issue && ret_valid) inflight_next = inflight_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_RUN;
      ptr_reg      <= '0;
      seq_reg      <= '0;
      exp_seq_reg  <= '0;
      inflight_reg <= '0;
      eng_fil_reg  <= '0;
      tag_err_reg  <= 1'b0;
    end else begin
      inflight_reg <= inflight_next;
      if (issue) begin
        seq_reg <= seq_reg + 1'b1;
        if (grant_idx == ID_W'(NUM_REQ - 1)) ptr_reg <= '0;
        else                                 ptr_reg <= grant_idx + 1'b1;
      end
      if (ret_valid) begin
        exp_seq_reg <= exp_seq_reg + 1'b1;
        if (ret_seq != exp_seq_reg) tag_err_reg <= 1'b1;
      end
      case (state_reg)
        ST_RUN:   if (cfg_valid) state_reg <= ST_DRAIN;
        ST_DRAIN: if (inflight_next == '0) state_reg <= ST_LOAD;
        ST_LOAD: begin
          eng_fil_reg <= cfg_fil;
          state_reg   <= ST_RUN;
        end
        default:  state_reg <= ST_RUN;
      endcase
    end
  end

  assign fifo_pop = !fifo_empty && res_ready;

  conv_result_fifo #(
    .WIDTH (RES_BITS + ID_W),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_valid),
    .push_data ({ret_id, eng_result}),
    .pop       (fifo_pop),
    .pop_data  ({res_id, res_data}),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign cfg_ready = (state_reg == ST_LOAD);
  assign eng_fil   = eng_fil_reg;
  assign tag_err   = tag_err_reg;
  assign busy      = (inflight_reg != '0) || !fifo_empty || (state_reg != ST_RUN);

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler with a latency-5 engine model.
module tb_conv_frame_scheduler;

  localparam int NR = 4;
  localparam int IB = 1024;
  localparam int FB = 576;
  localparam int RB = 1152;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*IB-1:0]  req_img;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FB-1:0]     cfg_fil;
  logic [IB-1:0]     eng_img;
  logic [FB-1:0]     eng_fil;
  logic [7:0]        eng_opaque_in;
  logic [7:0]        eng_opaque_out;
  logic [RB-1:0]     eng_result;
  logic              res_valid;
  logic              res_ready;
  logic [2:0]        res_id;
  logic [RB-1:0]     res_data;
  logic              busy;
  logic              tag_err;

  int total = 0;
  int bad   = 0;

  conv_frame_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_img        (req_img),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_fil        (cfg_fil),
    .eng_img        (eng_img),
    .eng_fil        (eng_fil),
    .eng_opaque_in  (eng_opaque_in),
    .eng_opaque_out (eng_opaque_out),
    .eng_result     (eng_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_data       (res_data),
    .busy           (busy),
    .tag_err        (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: five-stage pipeline, result = low image word ^ C0DE0000.
  bit [7:0]  pipe_opq [5];
  bit [31:0] pipe_dat [5];
  bit        corrupt;

  always @(posedge clk) begin
    pipe_opq[0] <= corrupt ? (eng_opaque_in + 8'd1) : eng_opaque_in;
    pipe_dat[0] <= eng_img[31:0] ^ 32'hC0DE0000;
    for (int i = 1; i < 5; i++) begin
      pipe_opq[i] <= pipe_opq[i-1];
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  assign eng_opaque_out = pipe_opq[4];
  assign eng_result     = {{(RB-32){1'b0}}, pipe_dat[4]};

  function automatic logic [31:0] exp_data(input int id);
    return (32'h100 + id) ^ 32'hC0DE0000;
  endfunction

  task automatic test_reset;
    reset = 1'b0; req_valid = 4'hF; res_ready = 1'b1; cfg_valid = 1'b0;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_cfg_ready got=%b want=0", cfg_ready); end
    total++; if (eng_opaque_in !== 8'h00) begin bad++; $display("FAIL reset_opaque got=%h want=00", eng_opaque_in); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%b want=0", tag_err); end
    total++; if (eng_fil !== '0) begin bad++; $display("FAIL reset_eng_fil got=%h want=0", eng_fil); end
    @(negedge clk);
    req_valid = 4'h0; reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_after got=%b want=0", busy); end
    $display("reset: checks done");
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [7:0] exp_tag;
    logic [2:0] exp_id;
    logic       exp_v;
    @(negedge clk);
    req_valid = 4'hF; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      exp_tag = {1'b1, 3'(k % 4), 4'(k)};
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, exp_rdy); end
      total++; if (eng_opaque_in !== exp_tag) begin bad++; $display("FAIL rr_tag k=%0d got=%h want=%h", k, eng_opaque_in, exp_tag); end
      total++; if (eng_img[31:0] !== 32'h100 + 32'(k % 4)) begin bad++; $display("FAIL rr_img k=%0d got=%h", k, eng_img[31:0]); end
      $display("rr issue k=%0d ready=%b tag=%h", k, req_ready, eng_opaque_in);
      @(negedge clk);
    end
    req_valid = 4'h0;
    for (int j = 5; j < 12; j++) begin
      #1;
      exp_v = (j >= 6) && (j <= 10);
      total++; if (res_valid !== exp_v) begin bad++; $display("FAIL rr_res_valid cyc=%0d got=%b want=%b", j, res_valid, exp_v); end
      if (exp_v) begin
        exp_id = 3'((j - 6) % 4);
        total++; if (res_id !== exp_id) begin bad++; $display("FAIL rr_res_id cyc=%0d got=%0d want=%0d", j, res_id, exp_id); end
        total++; if (res_data[31:0] !== exp_data(int'(exp_id))) begin bad++; $display("FAIL rr_res_data cyc=%0d got=%h want=%h", j, res_data[31:0], exp_data(int'(exp_id))); end
        $display("rr result cyc=%0d id=%0d data=%h", j, res_id, res_data[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_credit;
    int n;
    @(negedge clk);
    res_ready = 1'b0; req_valid = 4'b0100; n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[2]) n++;
      if (c == 0) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL credit_first got=%b want=0100", req_ready); end
      end
      @(negedge clk);
    end
    #1;
    total++; if (n != 8) begin bad++; $display("FAIL credit_issue_count got=%0d want=8", n); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL credit_blocked got=%b want=0000", req_ready); end
    total++; if (res_valid !== 1'b1 || res_id !== 3'd2) begin bad++; $display("FAIL credit_head got=%b/%0d want=1/2", res_valid, res_id); end
    $display("credit: issued %0d frames before stall", n);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready[2]) n++;
      @(negedge clk);
    end
    total++; if (n != 1) begin bad++; $display("FAIL credit_one_pop got=%0d want=1", n); end
    $display("credit: %0d issue after single pop", n);
    req_valid = 4'h0; res_ready = 1'b1; n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (res_valid) begin
        n++;
        total++; if (res_id !== 3'd2 || res_data[31:0] !== exp_data(2)) begin bad++; $display("FAIL credit_res got=%0d/%h want=2/%h", res_id, res_data[31:0], exp_data(2)); end
      end
      @(negedge clk);
    end
    total++; if (n != 8) begin bad++; $display("FAIL credit_drain_count got=%0d want=8", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL credit_idle got=%b want=0", busy); end
    $display("credit: drained %0d results", n);
  endtask

  task automatic test_cfg;
    logic [FB-1:0] pat;
    int n;
    pat = {18{32'hDEADBEEF}};
    @(negedge clk);
    req_valid = 4'b0001; res_ready = 1'b1; cfg_fil = pat; cfg_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL cfg_pre_issue j=%0d got=%b want=0001", j, req_ready); end
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    for (int j = 3; j < 9; j++) begin
      #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL cfg_block j=%0d got=%b want=0000", j, req_ready); end
      total++; if (cfg_ready !== (j == 8)) begin bad++; $display("FAIL cfg_ready j=%0d got=%b want=%b", j, cfg_ready, (j == 8)); end
      total++; if (eng_fil !== '0) begin bad++; $display("FAIL cfg_fil_early j=%0d", j); end
      $display("cfg cyc=%0d cfg_ready=%b busy=%b", j, cfg_ready, busy);
      if (j == 8) cfg_valid = 1'b0;
      @(negedge clk);
    end
    #1;
    total++; if (eng_fil !== pat) begin bad++; $display("FAIL cfg_fil_loaded got=%h", eng_fil[31:0]); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL cfg_resume got=%b want=0001", req_ready); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_drop got=%b want=0", cfg_ready); end
    @(negedge clk);
    req_valid = 4'h0; n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (res_valid) n++;
      @(negedge clk);
    end
    total++; if (n != 1) begin bad++; $display("FAIL cfg_post_results got=%0d want=1", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_idle got=%b want=0", busy); end
    $display("cfg: reload complete, %0d post-reload result", n);
  endtask

  task automatic test_tag_err;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req_valid = 4'b0001; res_ready = 1'b1;
    for (int j = 0; j < 13; j++) begin
      corrupt = (j == 2);
      if (j == 3) req_valid = 4'h0;
      #1;
      if (j <= 2) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL tag_issue j=%0d got=%b want=0001", j, req_ready); end
      end
      total++; if (tag_err !== (j >= 8)) begin bad++; $display("FAIL tag_err j=%0d got=%b want=%b", j, tag_err, (j >= 8)); end
      $display("tag cyc=%0d opq_out=%h tag_err=%b", j, eng_opaque_out, tag_err);
      @(negedge clk);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_reset_midflight;
    logic [3:0] exp_rdy;
    int nv;
    int nb;
    @(negedge clk);
    req_valid = 4'hF; res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      exp_rdy = 4'b0001 << ((j + 1) % 4);
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL mid_issue j=%0d got=%b want=%b", j, req_ready, exp_rdy); end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL mid_req_ready got=%b want=0", req_ready); end
    total++; if (eng_opaque_in !== 8'h00 || eng_img !== '0) begin bad++; $display("FAIL mid_eng got=%h want=00", eng_opaque_in); end
    total++; if (busy !== 1'b0 || tag_err !== 1'b0) begin bad++; $display("FAIL mid_busy_tag got=%b%b want=00", busy, tag_err); end
    total++; if (res_valid !== 1'b0 || res_id !== 3'd0 || res_data !== '0) begin bad++; $display("FAIL mid_res got=%b/%0d want=0/0", res_valid, res_id); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_cfg_ready got=%b want=0", cfg_ready); end
    @(negedge clk);
    reset = 1'b1; req_valid = 4'h0; nv = 0; nb = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (res_valid) nv++;
      if (busy) nb++;
      @(negedge clk);
    end
    total++; if (nv != 0) begin bad++; $display("FAIL mid_stale_results got=%0d want=0", nv); end
    total++; if (nb != 0) begin bad++; $display("FAIL mid_stale_busy got=%0d want=0", nb); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL mid_stale_tag got=%b want=0", tag_err); end
    $display("midflight reset: stale results=%0d", nv);
  endtask

  task automatic test_boundary;
    int n;
    int m;
    @(negedge clk);
    res_ready = 1'b0; req_valid = 4'b0010; n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[1]) n++;
      if (c == 7) begin
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bnd_issue_with_return got=%b want=0010", req_ready); end
      end
      if (c == 8) begin
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL bnd_full got=%b want=0000", req_ready); end
      end
      @(negedge clk);
    end
    total++; if (n != 8) begin bad++; $display("FAIL bnd_issue_count got=%0d want=8", n); end
    req_valid = 4'h0; res_ready = 1'b1; m = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (res_valid) begin
        m++;
        total++; if (res_id !== 3'd1 || res_data[31:0] !== exp_data(1)) begin bad++; $display("FAIL bnd_res got=%0d/%h want=1/%h", res_id, res_data[31:0], exp_data(1)); end
      end
      @(negedge clk);
    end
    total++; if (m != 8) begin bad++; $display("FAIL bnd_result_count got=%0d want=8", m); end
    total++; if (busy !== 1'b0 || tag_err !== 1'b0) begin bad++; $display("FAIL bnd_final got=%b%b want=00", busy, tag_err); end
    $display("boundary: issued=%0d results=%0d", n, m);
  endtask

  initial begin
    req_valid = '0;
    req_img   = '0;
    cfg_valid = 1'b0;
    cfg_fil   = '0;
    res_ready = 1'b0;
    corrupt   = 1'b0;
    reset     = 1'b0;
    for (int r = 0; r < NR; r++) req_img[r*IB +: 32] = 32'h100 + 32'(r);
    test_reset;
    test_round_robin;
    test_credit;
    test_cfg;
    test_tag_err;
    test_reset_midflight;
    test_boundary;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_frame_scheduler.md
CONV_FRAME_SCHEDULER -- requirements
Module: conv_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of frame requesters (2..8).
REQ-002 SHALL have parameter IMG_BITS, default 1024: flattened image frame width.
REQ-003 SHALL have parameter FIL_BITS, default 576: flattened filter set width.
REQ-004 SHALL have parameter RES_BITS, default 1152: flattened result frame width.
REQ-005 SHALL have parameter OUT_DEPTH, default 8: result buffer depth, power of two.
REQ-006 SHALL have ports: clk  input  1  single clock; reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports: req_valid  input  NUM_REQ; req_ready  output  NUM_REQ; req_img  input  NUM_REQ*IMG_BITS  per-requester frame, slice r at r*IMG_BITS.
REQ-008 SHALL have ports: cfg_valid  input  1; cfg_ready  output  1; cfg_fil  input  FIL_BITS  new filter set.
REQ-009 SHALL have ports: eng_img  output  IMG_BITS; eng_fil  output  FIL_BITS; eng_opaque_in  output  8; eng_opaque_out  input  8; eng_result  input  RES_BITS  (pipelined conv engine, fixed latency, opaque travels with data).
REQ-010 SHALL have ports: res_valid  output  1; res_ready  input  1; res_id  output  3  originating requester; res_data  output  RES_BITS.
REQ-011 SHALL have ports: busy  output  1; tag_err  output  1  sticky.

Function
REQ-012 Opaque format SHALL be bit7 valid, bits6:4 requester id, bits3:0 issue sequence number; eng_opaque_in SHALL be 0 in cycles without issue.
REQ-013 States SHALL be RUN, DRAIN, LOAD; reset state RUN.
REQ-014 In RUN, at most one frame SHALL issue per cycle, chosen round-robin among asserted req_valid starting after the last granted requester (pointer reset 0, so requester 0 wins first).
REQ-015 Issue SHALL require credit: inflight + buffer occupancy < OUT_DEPTH; without credit all req_ready SHALL be 0.
REQ-016 req_ready SHALL be one-hot of the grant, combinational from req_valid, pointer, credit and state; handshake is req_valid&req_ready.
REQ-017 On issue, eng_img SHALL carry the granted slice and eng_opaque_in the tag in the same cycle; sequence SHALL increment mod 16.
REQ-018 inflight SHALL increment on issue, decrement on eng_opaque_out[7]; simultaneous events SHALL leave it unchanged.
REQ-019 Returning eng_opaque_out[7]=1 SHALL push {id, eng_result} into the FIFO the same cycle; credit guarantees the FIFO never overflows.
REQ-020 Returning sequence SHALL equal expected return sequence (reset 0, +1 mod 16 per return); mismatch SHALL set tag_err until reset.
REQ-021 res_valid SHALL be FIFO non-empty; pop on res_valid&res_ready; simultaneous push and pop at full or empty SHALL be correct; push to empty SHALL appear on res_* the next cycle.
REQ-022 cfg_valid in RUN SHALL move to DRAIN and block new issues that cycle onward; cfg has priority over requests.
REQ-023 DRAIN SHALL move to LOAD when inflight==0; cfg_ready SHALL be 1 only in LOAD.
REQ-024 LOAD SHALL register cfg_fil into the eng_fil register and return to RUN next cycle; eng_fil SHALL never change while inflight>0.
REQ-025 busy SHALL be 1 when inflight>0, FIFO non-empty, or state != RUN.

Reset
REQ-026 On reset low: state RUN, pointer 0, sequences 0, inflight 0, FIFO empty, eng_fil 0, tag_err 0, all outputs 0, asynchronously.
REQ-027 Reset mid-operation SHALL discard in-flight tags; opaque returns with bit7=1 after reset release SHALL be ignored until the first post-reset issue.

Structure
REQ-028 Opaque field positions, state encoding and tag width SHALL live in shared package conv_sched_pkg.
REQ-029 Result buffer SHALL be sub-module conv_result_fifo (synchronous FIFO, count output).

Verification
REQ-030 All four req_valid high, res_ready high, engine latency 5: grants 0,1,2,3,0 in consecutive cycles; res_id sequence identical, 5+1 cycles later.
REQ-031 res_ready low, requester 2 streaming: exactly 8 frames issue, then req_ready=0 until a pop; one pop yields exactly one further issue.
REQ-032 cfg_valid with 3 frames in flight: no issue for those cycles, cfg_ready high one cycle after last return, eng_fil updates, issuing resumes next cycle.
REQ-033 Engine model returns sequence 3 when 2 expected: tag_err rises next cycle and stays high.
REQ-034 Reset asserted with 4 in flight: all outputs 0 immediately; stale returns after release produce no res_valid.
REQ-035 Issue and return in same cycle at full credit boundary: inflight unchanged, no overflow, no lost result.
